// File: rtl/obstacle_field.sv
// obstacle_field: NUM_OBS scrolling obstacle channels with LFSR respawn, nearest-obstacle, pixel-hit and pass reporting
module obstacle_field #(
  parameter int NUM_OBS = 4,
  parameter int X_W = 10,
  parameter int SCREEN_W = 160,
  parameter int OBS_W = 12,
  parameter int MIN_H = 7,
  parameter int MAX_H = 14,
  parameter int GROUND_Y = 105,
  parameter int MIN_GAP = 40,
  parameter int GAP_BITS = 6,
  parameter int NEAR_LEFT = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   clear,
  input  logic                   tick,
  input  logic                   run,
  input  logic [2:0]             speed,
  output logic [NUM_OBS*X_W-1:0] obs_x,
  output logic [NUM_OBS*8-1:0]   obs_h,
  output logic                   near_valid,
  output logic [2:0]             near_idx,
  output logic [X_W-1:0]         near_x,
  output logic [7:0]             near_h,
  input  logic [7:0]             query_x,
  input  logic [7:0]             query_y,
  output logic                   hit,
  output logic [2:0]             hit_idx,
  output logic                   passed
);
  localparam int XE = X_W + 1;
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? 16'h1 : LFSR_SEED;
  logic [X_W-1:0] x_q [NUM_OBS];
  logic [X_W-1:0] x_mv [NUM_OBS];
  logic [7:0]     h_q [NUM_OBS];
  logic [15:0]    lfsr;
  logic           acc, any_ret, nv, hv;
  logic [2:0]     sp_idx, n_idx, h_idx;
  logic [X_W-1:0] spd, tail, spawn_x, n_x;
  logic [XE-1:0]  spawn_sum, qx_e;
  logic [7:0]     spawn_h, n_h;
  logic [3:0]     r;
  always_comb begin
    spd = X_W'(speed);
    acc = tick & run & ~clear & (speed != 3'd0);
    any_ret = 1'b0;
    sp_idx = 3'd0;
    for (int i = NUM_OBS - 1; i >= 0; i--) begin
      x_mv[i] = (x_q[i] > spd) ? x_q[i] - spd : x_q[i];
      if (x_q[i] <= spd) begin
        any_ret = 1'b1;
        sp_idx = 3'(i);
      end
    end
    tail = '0;
    for (int i = 0; i < NUM_OBS; i++)
      if (!(any_ret && sp_idx == 3'(i)) && x_mv[i] > tail) tail = x_mv[i];
    // sum is one bit wider so overflow shows up as the top bit and saturates
    spawn_sum = {1'b0, tail} + XE'(MIN_GAP) + XE'(lfsr[GAP_BITS-1:0]);
    spawn_x = spawn_sum[X_W] ? '1 :
              (spawn_sum[X_W-1:0] < X_W'(SCREEN_W)) ? X_W'(SCREEN_W) : spawn_sum[X_W-1:0];
    r = lfsr[11:8];
    spawn_h = ({4'b0, r} > 8'(MAX_H - MIN_H)) ? 8'(MAX_H) : 8'(MIN_H) + {4'b0, r};
    nv = 1'b0;
    n_idx = 3'd0;
    n_x = '0;
    n_h = 8'd0;
    for (int i = 0; i < NUM_OBS; i++)
      if (x_q[i] >= X_W'(NEAR_LEFT) && (!nv || x_q[i] < n_x)) begin
        nv = 1'b1;
        n_idx = 3'(i);
        n_x = x_q[i];
        n_h = h_q[i];
      end
    qx_e = XE'(query_x);
    hv = 1'b0;
    h_idx = 3'd0;
    for (int i = 0; i < NUM_OBS; i++)
      if (!hv && qx_e >= {1'b0, x_q[i]} && qx_e < {1'b0, x_q[i]} + XE'(OBS_W) &&
          {1'b0, query_y} >= 9'(GROUND_Y) - {1'b0, h_q[i]} && {1'b0, query_y} < 9'(GROUND_Y)) begin
        hv = 1'b1;
        h_idx = 3'(i);
      end
  end
  always_ff @(posedge clk) begin
    lfsr <= !resetn ? SEED : ({1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0));
    for (int i = 0; i < NUM_OBS; i++) begin
      if (!resetn || clear) begin
        x_q[i] <= X_W'(SCREEN_W + i * (MIN_GAP + 2 ** (GAP_BITS - 1)));
        h_q[i] <= 8'((i % 2 == 1) ? MAX_H : MIN_H);
      end else if (acc) begin
        x_q[i] <= (any_ret && sp_idx == 3'(i)) ? spawn_x : x_mv[i];
        h_q[i] <= (any_ret && sp_idx == 3'(i)) ? spawn_h : h_q[i];
      end
    end
    passed <= resetn & acc & any_ret;
    hit <= resetn & ~clear & hv;
    hit_idx <= (resetn && !clear) ? h_idx : 3'd0;
    if (!resetn) begin
      near_valid <= 1'b1;
      near_idx <= 3'd0;
      near_x <= X_W'(SCREEN_W);
      near_h <= 8'(MIN_H);
    end else begin
      near_valid <= nv;
      if (nv) begin
        near_idx <= n_idx;
        near_x <= n_x;
        near_h <= n_h;
      end
    end
  end
  for (genvar g = 0; g < NUM_OBS; g++) begin : g_pack
    assign obs_x[g*X_W +: X_W] = x_q[g];
    assign obs_h[g*8 +: 8] = h_q[g];
  end
endmodule

// File: tb/tb_obstacle_field.sv
// tb_obstacle_field: randomized and directed checks of obstacle_field against an integer reference model
module tb_obstacle_field;
  localparam int N = 4;
  logic clk = 0, resetn = 0, clear = 0, tick = 0, run = 0;
  logic [2:0] speed = 0;
  logic [7:0] query_x = 0, query_y = 0;
  logic [N*10-1:0] obs_x;
  logic [N*8-1:0] obs_h;
  logic near_valid, hit, passed;
  logic [2:0] near_idx, hit_idx;
  logic [9:0] near_x;
  logic [7:0] near_h;
  logic tick2 = 0;
  logic [19:0] obs_x2;
  logic [15:0] obs_h2;
  logic nv2, hit2, passed2;
  logic [2:0] ni2, hi2;
  logic [9:0] nx2;
  logic [7:0] nh2;
  int checks = 0, errors = 0;
  int mx[N], mh[N];
  int ml, mp, env, eidx, ex, eh, ehit, ehidx;

  obstacle_field dut (
    .clk(clk), .resetn(resetn), .clear(clear), .tick(tick), .run(run), .speed(speed),
    .obs_x(obs_x), .obs_h(obs_h), .near_valid(near_valid), .near_idx(near_idx),
    .near_x(near_x), .near_h(near_h), .query_x(query_x), .query_y(query_y),
    .hit(hit), .hit_idx(hit_idx), .passed(passed)
  );

  // tight layout (spacing 2) so two channels retire on the same tick
  obstacle_field #(.NUM_OBS(2), .MIN_GAP(1), .GAP_BITS(1)) u2 (
    .clk(clk), .resetn(resetn), .clear(1'b0), .tick(tick2), .run(1'b1), .speed(3'd3),
    .obs_x(obs_x2), .obs_h(obs_h2), .near_valid(nv2), .near_idx(ni2),
    .near_x(nx2), .near_h(nh2), .query_x(8'd0), .query_y(8'd0),
    .hit(hit2), .hit_idx(hi2), .passed(passed2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic layout();
    for (int i = 0; i < N; i++) begin
      mx[i] = 160 + i * 72;
      mh[i] = (i % 2 == 1) ? 14 : 7;
    end
  endtask

  task automatic cyc(input int t, input int r, input int c, input int rn, input int sp, input int qx, input int qy);
    int who, tail, s, rr, bi;
    tick = 1'(t); run = 1'(r); clear = 1'(c); resetn = 1'(rn);
    speed = 3'(sp); query_x = 8'(qx); query_y = 8'(qy);
    if (rn == 0) begin
      env = 1; eidx = 0; ex = 160; eh = 7; ehit = 0; ehidx = 0;
    end else begin
      bi = -1;
      for (int i = 0; i < N; i++)
        if (mx[i] >= 3 && (bi < 0 || mx[i] < mx[bi])) bi = i;
      env = (bi >= 0);
      if (bi >= 0) begin eidx = bi; ex = mx[bi]; eh = mh[bi]; end
      ehit = 0; ehidx = 0;
      if (c == 0)
        for (int i = 0; i < N; i++)
          if (ehit == 0 && qx >= mx[i] && qx < mx[i] + 12 && qy >= 105 - mh[i] && qy < 105) begin
            ehit = 1; ehidx = i;
          end
    end
    mp = 0;
    if (rn == 0) begin
      layout();
      ml = 'hACE1;
    end else begin
      if (c != 0) layout();
      else if (t != 0 && r != 0 && sp != 0) begin
        who = -1;
        for (int i = 0; i < N; i++) if (who < 0 && mx[i] <= sp) who = i;
        for (int i = 0; i < N; i++) if (i != who && mx[i] > sp) mx[i] -= sp;
        if (who >= 0) begin
          tail = 0;
          for (int i = 0; i < N; i++) if (i != who && mx[i] > tail) tail = mx[i];
          s = tail + 40 + (ml % 64);
          if (s > 1023) s = 1023;
          if (s < 160) s = 160;
          rr = (ml >> 8) % 16;
          mx[who] = s;
          mh[who] = (rr > 7) ? 14 : 7 + rr;
          mp = 1;
        end
      end
      ml = (ml >> 1) ^ (((ml & 1) != 0) ? 'hB400 : 0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("x%0d", i), obs_x[i*10 +: 10], mx[i]);
      chk($sformatf("h%0d", i), obs_h[i*8 +: 8], mh[i]);
    end
    chk("passed", passed, mp);
    chk("near_valid", near_valid, env);
    chk("near_idx", near_idx, eidx);
    chk("near_x", near_x, ex);
    chk("near_h", near_h, eh);
    chk("hit", hit, ehit);
    chk("hit_idx", hit_idx, ehidx);
  endtask

  initial begin
    int np;
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 165, 100);
    chk("q165_100_hit", hit, 1);
    chk("q165_100_idx", hit_idx, 0);
    cyc(0, 0, 0, 1, 0, 165, 97);
    chk("q165_97_hit", hit, 0);
    cyc(0, 0, 0, 1, 0, 172, 100);
    chk("q172_100_hit", hit, 0);
    cyc(0, 0, 0, 1, 0, 159, 104);
    chk("q159_104_hit", hit, 0);
    chk("init_obs_x", obs_x, {10'd376, 10'd304, 10'd232, 10'd160});
    chk("init_obs_h", obs_h, {8'd14, 8'd7, 8'd14, 8'd7});
    chk("init_near", {near_valid, near_idx, near_x, near_h}, {1'b1, 3'd0, 10'd160, 8'd7});
    cyc(1, 1, 0, 1, 2, 0, 0);
    chk("tick1_x", obs_x, {10'd374, 10'd302, 10'd230, 10'd158});
    for (int k = 0; k < 10; k++) cyc(1, 1, 0, 1, 0, 0, 0);
    for (int k = 0; k < 10; k++) cyc(1, 0, 0, 1, 2, 0, 0);
    chk("frozen_x", obs_x, {10'd374, 10'd302, 10'd230, 10'd158});
    np = 0;
    for (int k = 0; k < 78; k++) begin
      cyc(1, 1, 0, 1, 2, 0, 0);
      np += int'(passed);
    end
    chk("no_early_pass", np, 0);
    cyc(1, 1, 0, 1, 2, 0, 0);
    chk("tick80_passed", passed, 1);
    chk("respawn_x_range", (obs_x[9:0] >= 256 && obs_x[9:0] <= 319), 1);
    chk("respawn_h_range", (obs_h[7:0] >= 7 && obs_h[7:0] <= 14), 1);
    chk("others_x", obs_x[39:10], {10'd216, 10'd144, 10'd72});
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("pulse_end", passed, 0);
    chk("near_idx_1", near_idx, 1);
    for (int k = 0; k < 20; k++) cyc(1, 1, 0, 1, 3, 0, 0);
    cyc(1, 1, 1, 1, 3, 0, 0);
    chk("clear_x", obs_x, {10'd376, 10'd304, 10'd232, 10'd160});
    chk("clear_passed", passed, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 3000; k++)
      cyc($urandom_range(0, 1), int'($urandom_range(0, 7) != 0), int'($urandom_range(0, 99) == 0),
          int'($urandom_range(0, 499) != 0), $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(88, 110));
    cyc(0, 0, 0, 0, 0, 0, 0);
    np = 0;
    tick2 = 1;
    for (int k = 0; k < 53; k++) begin
      cyc(0, 0, 0, 1, 0, 0, 0);
      np += int'(passed2);
    end
    chk("u2_no_early_pass", np, 0);
    chk("u2_pre_x", obs_x2, {10'd3, 10'd1});
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("u2_first_x", obs_x2, {10'd3, 10'd160});
    chk("u2_first_pass", passed2, 1);
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("u2_second_x", obs_x2, {10'd160, 10'd157});
    chk("u2_second_pass", passed2, 1);
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("u2_after_x", obs_x2, {10'd157, 10'd154});
    chk("u2_after_pass", passed2, 0);
    tick2 = 0;
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("u2_idle_pass", passed2, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/obstacle_field.md
Name: obstacle_field

Overview:
Parametrised multi-channel obstacle manager for the runner game. It replaces the fixed two-obstacle datapath with NUM_OBS obstacle channels. Each channel scrolls left at a programmable speed and respawns at the right edge with LFSR-derived height and gap. The block also reports the nearest obstacle for collision logic, answers per-pixel hit queries for the renderer, and pulses once per cleared obstacle for the score counter.

Parameters:
NUM_OBS, 4, number of obstacle channels (2..8)
X_W, 10, obstacle X coordinate width (unsigned)
SCREEN_W, 160, minimum respawn X
OBS_W, 12, obstacle width in pixels
MIN_H, 7, minimum obstacle height
MAX_H, 14, maximum obstacle height
GROUND_Y, 105, first ground row; obstacles occupy rows GROUND_Y-h .. GROUND_Y-1
MIN_GAP, 40, minimum spacing between an obstacle's X and the previous tail X
GAP_BITS, 6, random gap range 0..2^GAP_BITS-1 added to MIN_GAP
NEAR_LEFT, 3, leftmost X still considered for collision (dino left edge minus OBS_W)
LFSR_SEED, 16'hACE1, LFSR reset value; 0 is replaced by 1

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
clear  in  1  restore initial layout (asserted while the game is in menu)
tick  in  1  one-cycle frame strobe; movement step
run  in  1  movement enable; tick is ignored when low
speed  in  3  pixels moved per accepted tick
obs_x  out  NUM_OBS*X_W  packed X per channel; channel i occupies bits [i*X_W +: X_W]
obs_h  out  NUM_OBS*8  packed height per channel
near_valid  out  1  a nearest obstacle exists
near_idx  out  3  channel index of the nearest obstacle
near_x  out  X_W  X of the nearest obstacle
near_h  out  8  height of the nearest obstacle
query_x  in  8  renderer pixel X
query_y  in  8  renderer pixel Y
hit  out  1  queried pixel lies inside an obstacle
hit_idx  out  3  lowest-index channel covering the queried pixel
passed  out  1  one-cycle pulse when a channel respawns

Behaviour:
- Reset and clear are synchronous and load the initial layout. Reset has priority over clear; clear has priority over tick.
  - Channel i: x = SCREEN_W + i*(MIN_GAP + 2^(GAP_BITS-1)). Defaults give 160, 232, 304, 376.
  - Height: MIN_H for even i, MAX_H for odd i.
  - passed=0, hit=0, hit_idx=0.
  - near_* reflect the initial layout one cycle later: near_valid=1, near_idx=0, near_x=160, near_h=7.
- LFSR:
  - 16-bit Galois, mask 16'hB400, shift right.
  - Steps every cycle while resetn=1, including during clear, so player timing randomises the sequence.
  - Loaded with LFSR_SEED only on reset.
- Accepted tick (tick & run & !clear & speed!=0). Per channel:
  - If x > speed: x <= x - speed.
  - Otherwise the channel is retiring.
- Retire and respawn:
  - Only the lowest-index retiring channel respawns on a given tick. Other retiring channels hold their X and retry on later ticks, one per tick.
  - tail = maximum post-move X over all non-respawning channels.
  - spawn = max(SCREEN_W, tail + MIN_GAP + lfsr[GAP_BITS-1:0]), computed at X_W+1 bits and saturated to 2^X_W-1.
  - r = lfsr[11:8]. New h = MAX_H if r > MAX_H-MIN_H, else MIN_H + r.
  - passed=1 for exactly the cycle after the respawning tick; 0 otherwise.
- speed=0 or run=0: positions frozen, no respawn, no passed pulse.
- Nearest obstacle (registered, 1-cycle latency):
  - The channel with the smallest x satisfying x >= NEAR_LEFT; ties go to the lower index.
  - If no channel qualifies: near_valid=0 and near_idx/near_x/near_h hold their previous values.
- Pixel query (registered, 1-cycle latency):
  - hit=1 iff some channel satisfies x <= query_x < x+OBS_W and GROUND_Y-h <= query_y < GROUND_Y.
  - Comparisons are done at X_W+1 bits, so query_x is zero-extended and no wrap occurs.
  - hit_idx is the lowest covering channel; it is 0 when hit=0.
- obs_x and obs_h are driven directly from the state registers (0 latency).

Test Plan:
- Reset then idle 3 cycles -> obs_x = {376,304,232,160}, obs_h = {14,7,14,7}; near_idx=0, near_x=160, near_h=7; passed never asserted.
- run=1, speed=2, 1 tick -> next cycle x = 158,230,302,374; speed=0 or run=0 with 10 ticks -> no change.
- speed=2, 80 ticks -> on the 80th tick channel 0 respawns with 256 <= x <= 319 and 7 <= h <= 14; passed is high exactly 1 cycle; other channels read 72,144,216; near_idx becomes 1.
- Force simultaneous retirement (speed=7 after channels converge, or a reduced NUM_OBS=2 layout) -> only the lower index respawns on that tick, the other respawns on the next tick; 2 separate passed pulses.
- After reset, query (165,100) -> hit=1, hit_idx=0 next cycle; (165,97) -> hit=0; (172,100) -> hit=0; (159,104) -> hit=0.
- Mid-game clear asserted together with tick -> initial layout restored, tick ignored, no passed pulse; the LFSR sequence continues (the next respawn height/gap differs from the one after reset).
